// File: rtl/key_load_seq_if.sv
// rtl/key_load_seq_if.sv - control and key bus between a serial key source and key_load_seq
interface key_load_seq_if #(
    parameter int KEY_W = 36
);
    logic             start;
    logic             sdi;
    logic             sdi_vld;
    logic [KEY_W-1:0] key_out;
    logic             key_vld;
    logic             busy;
    logic             err;

    modport master (
        output start, sdi, sdi_vld,
        input  key_out, key_vld, busy, err
    );

    modport slave (
        input  start, sdi, sdi_vld,
        output key_out, key_vld, busy, err
    );
endinterface

// File: rtl/key_load_seq.sv
// rtl/key_load_seq.sv - serial key loader for the locked c432; KEY_PARITY_CHK_EN enables the trailing parity bit
module key_load_seq #(
    parameter int KEY_W = 36,
    parameter int CNT_W = 6
) (
    input  logic           CK,
    input  logic           RST,
    key_load_seq_if.slave  bus
);

`ifdef KEY_PARITY_CHK_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        PAR   = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        DONE  = 3'd3
    } state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

    state_t             state;
    state_t             state_next;
    logic [KEY_W-1:0]   shadow;
    logic [KEY_W-1:0]   shadow_next;
    logic [KEY_W-1:0]   key_q;
    logic [CNT_W-1:0]   cnt;
    logic               shift_bit;
    logic               last_bit;
    logic               commit;
    logic               busy_c;
    logic               key_vld_c;
    logic               err_c;

    // A bit presented together with start belongs to the aborted load and is dropped.
    assign shift_bit = bus.sdi_vld && !bus.start && (state == SHIFT);
    assign last_bit  = shift_bit && (cnt == LAST_IDX);

`ifdef KEY_PARITY_CHK_EN
    logic par_bit;
    logic par_ok;

    assign par_bit = bus.sdi_vld && !bus.start && (state == PAR);
    assign par_ok  = (bus.sdi == ^shadow);
    assign commit  = par_bit && par_ok;
`else
    assign commit  = last_bit;
`endif

    always_comb begin
        shadow_next = shadow;
        if (shift_bit) begin
            shadow_next[cnt] = bus.sdi;
        end
    end

    // State register
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (bus.start) begin
            state_next = SHIFT;
        end else begin
            case (state)
                SHIFT: begin
`ifdef KEY_PARITY_CHK_EN
                    if (last_bit) state_next = PAR;
`else
                    if (last_bit) state_next = DONE;
`endif
                end
`ifdef KEY_PARITY_CHK_EN
                PAR: begin
                    if (par_bit) state_next = par_ok ? DONE : ERR;
                end
`endif
                default: state_next = state;
            endcase
        end
    end

    // Output decode; every output is a function of registered state only.
    always_comb begin
        busy_c    = 1'b0;
        key_vld_c = 1'b0;
        err_c     = 1'b0;
        case (state)
            SHIFT: busy_c    = 1'b1;
`ifdef KEY_PARITY_CHK_EN
            PAR:   busy_c    = 1'b1;
            ERR:   err_c     = 1'b1;
`endif
            DONE:  key_vld_c = 1'b1;
            default: ;
        endcase
    end

    // Key bus only ever switches between all-zeros and a complete shadow copy.
    always_ff @(posedge CK) begin
        if (RST || bus.start) begin
            shadow <= '0;
            cnt    <= '0;
            key_q  <= '0;
        end else begin
            if (shift_bit) begin
                shadow <= shadow_next;
                if (cnt != LAST_IDX) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (commit) begin
                key_q <= shadow_next;
            end
        end
    end

    assign bus.key_out = key_q;
    assign bus.key_vld = key_vld_c;
    assign bus.busy    = busy_c;
    assign bus.err     = err_c;

    a_cnt_range: assert property (@(posedge CK) disable iff (RST) cnt <= LAST_IDX);
    a_key_zero:  assert property (@(posedge CK) disable iff (RST) (state != DONE) |-> (key_q == '0));

endmodule

// File: doc/key_load_seq.md
# key_load_seq

Serial key loader that sits directly upstream of the MUX-locked c432 netlist and drives its 36 key inputs p1..p36. It shifts a key in one bit per accepted cycle, optionally checks a trailing even-parity bit, and presents the key on a registered bus. Until a full, checked key has been committed, the key bus is held at all-zeros, so the locked circuit computes a wrong function.

## Interface
- KEY_W, 36, key length in bits; bit i of key_out drives p(i+1).
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > KEY_W.

Ports:
- CK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins or restarts a load.
- sdi  in  1  serial key data; LSB first (first bit → key bit 0 / p1).
- sdi_vld  in  1  qualifies sdi; a bit is accepted on any rising edge where sdi_vld=1 in SHIFT or PAR.
- key_out  out  KEY_W  committed key, or all-zeros when no valid key is held.
- key_vld  out  1  high while key_out holds a committed key.
- busy  out  1  high in SHIFT or PAR.
- err  out  1  high in ERR.

## Operation
- States: IDLE, SHIFT, PAR, DONE, ERR. Reset → IDLE. Reset values: key_out=0, key_vld=0, busy=0, err=0, shadow=0, cnt=0.
- IDLE: start → SHIFT, shadow cleared, cnt=0. sdi_vld is ignored.
- SHIFT: on an accepted bit, shadow[cnt]=sdi and cnt=cnt+1. sdi_vld=0 holds state; gaps of any length are legal. The bit accepted with cnt=KEY_W-1 is the last key bit.
  - With parity: last key bit → PAR.
  - Without parity: last key bit → DONE; key_out takes the full shadow, including that bit, on the same edge.
- PAR: the next accepted bit is the parity bit. It must equal the XOR of all KEY_W shadow bits.
  - Match → DONE; key_out=shadow.
  - Mismatch → ERR; key_out stays 0.
- DONE: key_vld=1 and key_out is held. sdi_vld is ignored.
- ERR: err=1, key_out=0, key_vld=0. Left only by start or RST.
- start in any state, including mid-SHIFT, mid-PAR, DONE or ERR: on that edge, key_out=0, key_vld=0, err=0, shadow=0, cnt=0, next state SHIFT. A bit presented with sdi_vld on the same edge as start is discarded.
- RST overrides start and sdi_vld in every state.
- key_out is never partially updated. It changes only to all-zeros or to a complete shadow copy.
- cnt never exceeds KEY_W-1; it has no wrap-around path.

## Timing
- Load latency: key_vld rises on the same edge that accepts the final bit. That is the parity bit with parity, or key bit KEY_W-1 without it.
- Minimum load time: KEY_W+1 accepted cycles with parity, KEY_W without. Start adds one cycle.
- err rises on the edge that accepts a bad parity bit.
- busy rises on the edge after start and falls on the edge that accepts the final bit.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- KEY_PARITY_CHK_EN defined: the PAR state exists, the parity bit is required, and err is functional.
- Not defined: the PAR state and parity logic are removed; SHIFT goes straight to DONE after bit KEY_W-1, and err is tied 0.

## Test plan
- Reset, then idle for 10 cycles with sdi_vld toggling → key_out=36'h0, key_vld=0, busy=0, err=0 throughout.
- start, then 36 bits of 36'hA_5A5A_5A5A (18 ones) and parity 0 → key_vld=1 on the parity edge, key_out=36'hA_5A5A_5A5A. Without the macro: key_vld on the 36th edge, no parity bit sent.
- start, then 36'h0_0000_0001 with parity 0 (macro on) → err=1, key_out=0, key_vld=0. A following start clears err the next cycle.
- start, 20 bits, then start again and a full load of 36'hF_0000_000F with parity 0 → key_out=36'hF_0000_000F. The first 20 bits leave no trace.
- Load 36'h1_2345_6789 (parity 1) with random sdi_vld gaps of 0–5 cycles → correct key_out, and busy high exactly from start+1 to the final edge.
- From DONE, assert RST for 1 cycle and, separately, pulse start → both clear key_out to 0 and key_vld to 0 on that edge. After RST the state is IDLE; after start it is SHIFT.
